// File: rtl/axis_integrator_if.sv
// AXI-Stream channel bundle (valid/ready/data).
// The master drives tvalid and tdata. The slave drives tready.
interface axis_integrator_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_integrator.sv
// Streaming signed integrator with an optional leak and saturating accumulator/output.
// One result is produced per accepted sample, one cycle after the accept, with full AXI-Stream backpressure.
module axis_integrator #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int ACC_WIDTH        = 32,
    parameter int OUT_SHIFT        = 8,
    parameter int LEAK_SHIFT       = 0
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 clear,
    axis_integrator_if.slave     S_AXIS,
    axis_integrator_if.master    M_AXIS,
    output logic                 overflow
);
    localparam int SW = ACC_WIDTH + 2;
    localparam int W  = AXIS_TDATA_WIDTH;

    localparam logic signed [SW-1:0] ACC_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = {{(ACC_WIDTH-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = {{(ACC_WIDTH-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic signed [W-1:0]         out_data_reg;
    logic                        out_valid_reg;
    logic                        overflow_reg;

    logic                        ready;
    logic                        accept;
    logic signed [W-1:0]         din;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] leak;
    logic signed [SW-1:0]        sum;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [W-1:0]         out_next;
    logic                        acc_clamp;
    logic                        out_clamp;

    assign ready           = ~out_valid_reg | M_AXIS.tready;
    assign accept          = S_AXIS.tvalid & ready;
    assign din             = S_AXIS.tdata;
    assign S_AXIS.tready   = ready;
    assign M_AXIS.tvalid   = out_valid_reg;
    assign M_AXIS.tdata    = out_data_reg;
    assign overflow        = overflow_reg;

    always_comb begin
        base      = clear ? '0 : acc_reg;
        leak      = (LEAK_SHIFT == 0 || clear) ? '0 : (base >>> LEAK_SHIFT);
        // Widen by two bits so base + x - leak can never wrap before clamping.
        sum       = {{2{base[ACC_WIDTH-1]}}, base}
                  + {{(SW-W){din[W-1]}}, din}
                  - {{2{leak[ACC_WIDTH-1]}}, leak};
        acc_clamp = 1'b0;
        acc_next  = sum[ACC_WIDTH-1:0];
        if (sum > ACC_MAX) begin
            acc_next  = ACC_MAX[ACC_WIDTH-1:0];
            acc_clamp = 1'b1;
        end else if (sum < ACC_MIN) begin
            acc_next  = ACC_MIN[ACC_WIDTH-1:0];
            acc_clamp = 1'b1;
        end
        shifted   = acc_next >>> OUT_SHIFT;
        out_clamp = 1'b0;
        out_next  = shifted[W-1:0];
        if (shifted > OUT_MAX) begin
            out_next  = OUT_MAX[W-1:0];
            out_clamp = 1'b1;
        end else if (shifted < OUT_MIN) begin
            out_next  = OUT_MIN[W-1:0];
            out_clamp = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (accept) begin
            acc_reg       <= acc_next;
            out_data_reg  <= out_next;
            out_valid_reg <= 1'b1;
            // A clear that coincides with a sample restarts the sticky flag from this sample alone.
            overflow_reg  <= (clear ? 1'b0 : overflow_reg) | acc_clamp | out_clamp;
        end else begin
            if (out_valid_reg && M_AXIS.tready) begin
                out_valid_reg <= 1'b0;
            end
            if (clear) begin
                acc_reg      <= '0;
                overflow_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_integrator.sv
// Directed bench for axis_integrator: reset, ramp, backpressure, saturation, clear, async reset and leak.
// dut0 is a pure integrator with OUT_SHIFT=0. dut1 uses LEAK_SHIFT=2.
module tb_axis_integrator;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic clear0 = 1'b0;
    logic clear1 = 1'b0;
    logic ovf0;
    logic ovf1;
    int   total = 0;
    int   passed = 0;

    always #5 aclk = ~aclk;

    axis_integrator_if #(.DATA_WIDTH(16)) s0 ();
    axis_integrator_if #(.DATA_WIDTH(16)) m0 ();
    axis_integrator_if #(.DATA_WIDTH(16)) s1 ();
    axis_integrator_if #(.DATA_WIDTH(16)) m1 ();

    axis_integrator #(.AXIS_TDATA_WIDTH(16), .ACC_WIDTH(32), .OUT_SHIFT(0), .LEAK_SHIFT(0)) dut0 (
        .aclk(aclk), .aresetn(aresetn), .clear(clear0),
        .S_AXIS(s0), .M_AXIS(m0), .overflow(ovf0)
    );

    axis_integrator #(.AXIS_TDATA_WIDTH(16), .ACC_WIDTH(32), .OUT_SHIFT(0), .LEAK_SHIFT(2)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .clear(clear1),
        .S_AXIS(s1), .M_AXIS(m1), .overflow(ovf1)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        logic signed [31:0] prev;
        s0.tvalid = 1'b0; s0.tdata = '0; m0.tready = 1'b1;
        s1.tvalid = 1'b0; s1.tdata = '0; m1.tready = 1'b1;

        // Reset held with random stimulus.
        for (int i = 0; i < 4; i++) begin
            s0.tvalid = 1'($urandom); s0.tdata = 16'($urandom); clear0 = 1'($urandom);
            m0.tready = 1'($urandom);
            tick();
        end
        chk("rst_tvalid", {31'b0, m0.tvalid}, 0);
        chk("rst_tdata", $signed(m0.tdata), 0);
        chk("rst_ovf", {31'b0, ovf0}, 0);
        chk("rst_tready", {31'b0, s0.tready}, 1);
        s0.tvalid = 1'b0; clear0 = 1'b0; m0.tready = 1'b1;
        #2 aresetn = 1'b1;

        // First sample after reset.
        tick();
        s0.tvalid = 1'b1; s0.tdata = 16'sd5;
        tick();
        s0.tvalid = 1'b0;
        chk("first_valid", {31'b0, m0.tvalid}, 1);
        chk("first_data", $signed(m0.tdata), 5);
        tick();
        chk("drain_valid", {31'b0, m0.tvalid}, 0);
        chk("drain_hold", $signed(m0.tdata), 5);

        // Ramp of ten samples of 100, restarting the accumulator with clear.
        for (int i = 0; i < 10; i++) begin
            s0.tvalid = 1'b1; s0.tdata = 16'sd100; clear0 = (i == 0);
            tick();
            chk($sformatf("ramp%0d", i), $signed(m0.tdata), 100 * (i + 1));
            chk($sformatf("ramp_v%0d", i), {31'b0, m0.tvalid}, 1);
        end
        clear0 = 1'b0; s0.tvalid = 1'b0;
        tick();

        // Backpressure after the third output.
        for (int i = 0; i < 3; i++) begin
            s0.tvalid = 1'b1; s0.tdata = 16'sd100; clear0 = (i == 0);
            tick();
            chk($sformatf("bp_pre%0d", i), $signed(m0.tdata), 100 * (i + 1));
        end
        clear0 = 1'b0;
        m0.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_tready%0d", i), {31'b0, s0.tready}, 0);
            tick();
            chk($sformatf("bp_hold%0d", i), $signed(m0.tdata), 300);
            chk($sformatf("bp_valid%0d", i), {31'b0, m0.tvalid}, 1);
        end
        m0.tready = 1'b1;
        for (int k = 4; k <= 10; k++) begin
            tick();
            chk($sformatf("bp_post%0d", k), $signed(m0.tdata), 100 * k);
        end
        s0.tvalid = 1'b0;
        tick();

        // Positive saturation, clear, negative saturation.
        s0.tvalid = 1'b1; s0.tdata = 16'sd32767; clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        chk("satp0", $signed(m0.tdata), 32767);
        chk("satp0_ovf", {31'b0, ovf0}, 0);
        tick();
        chk("satp1", $signed(m0.tdata), 32767);
        chk("satp1_ovf", {31'b0, ovf0}, 1);
        s0.tvalid = 1'b0; clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        chk("clr_ovf", {31'b0, ovf0}, 0);
        s0.tvalid = 1'b1; s0.tdata = -16'sd32768;
        tick();
        chk("satn0", $signed(m0.tdata), -32768);
        chk("satn0_ovf", {31'b0, ovf0}, 0);
        tick();
        chk("satn1", $signed(m0.tdata), -32768);
        chk("satn1_ovf", {31'b0, ovf0}, 1);

        // Clear with accept mid-stream, then asynchronous reset.
        s0.tdata = 16'sd1000; clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        chk("acc1000", $signed(m0.tdata), 1000);
        s0.tdata = 16'sd7; clear0 = 1'b1;
        tick();
        clear0 = 1'b0; s0.tvalid = 1'b0; m0.tready = 1'b0;
        chk("clr_acc7", $signed(m0.tdata), 7);
        chk("clr_acc7_ovf", {31'b0, ovf0}, 0);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_valid", {31'b0, m0.tvalid}, 0);
        chk("arst_data", $signed(m0.tdata), 0);
        #1 aresetn = 1'b1;
        m0.tready = 1'b1;
        tick();
        s0.tvalid = 1'b1; s0.tdata = 16'sd3;
        tick();
        s0.tvalid = 1'b0;
        chk("post_rst", $signed(m0.tdata), 3);

        // Leak: constant 64 converges to 256 from below.
        s1.tvalid = 1'b1; s1.tdata = 16'sd64;
        tick(); chk("leak0", $signed(m1.tdata), 64);
        tick(); chk("leak1", $signed(m1.tdata), 112);
        tick(); chk("leak2", $signed(m1.tdata), 148);
        tick(); chk("leak3", $signed(m1.tdata), 175);
        prev = 175;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("leak_bound%0d", i), {31'b0, ($signed(m1.tdata) <= 256 && $signed(m1.tdata) >= prev)}, 1);
            prev = $signed(m1.tdata);
        end
        chk("leak_final", $signed(m1.tdata), 256);
        s1.tvalid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
